// File: rtl/conv_frame_ctrl_pkg.sv
// Shared types for the convolution frame controller: FSM states, the window tag
// carried alongside each datapath shift, and counter width helpers.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Tag coordinates are stored at a fixed width wide enough for any frame;
  // the top slices them down to the configured output widths.
  localparam int TAG_COORD_W = 16;

  typedef struct packed {
    logic                   ok;
    logic [TAG_COORD_W-1:0] orow;
    logic [TAG_COORD_W-1:0] ocol;
  } tag_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_frame_ctrl_if.sv
// Pixel input stream and result output stream of the frame controller.
interface conv_frame_ctrl_if #(
  parameter int WORD_SIZE = 8,
  parameter int ROW_W     = 9,
  parameter int COL_W     = 10
);
  // Input: a pixel transfers on a cycle where s_valid and s_ready are both high;
  // s_pixel must be stable while s_valid is high. Output has no backpressure:
  // m_* are meaningful only when m_valid is high and must be taken that cycle.
  logic                 s_valid;
  logic                 s_ready;
  logic [WORD_SIZE-1:0] s_pixel;
  logic                 m_valid;
  logic [WORD_SIZE-1:0] m_pixel;
  logic [ROW_W-1:0]     m_row;
  logic [COL_W-1:0]     m_col;
  logic                 m_last;

  modport slave (
    input  s_valid, s_pixel,
    output s_ready, m_valid, m_pixel, m_row, m_col, m_last
  );

  modport master (
    output s_valid, s_pixel,
    input  s_ready, m_valid, m_pixel, m_row, m_col, m_last
  );
endinterface

// File: rtl/conv_frame_ctrl_tag_pipe.sv
// Fixed-depth shift register of window tags that tracks datapath latency;
// empty is high when no stage holds a tag for a complete window.
module conv_tag_pipe
  import conv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out,
  output logic empty
);

  tag_t stage_q [DEPTH];
  tag_t stage_d [DEPTH];

  always_comb begin
    stage_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  always_comb begin
    empty = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (stage_q[i].ok) empty = 1'b0;
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the convolution line-buffer datapath: gates pixel shifts,
// tracks raster position and emits only complete-window results with coordinates.
module conv_frame_ctrl
  import conv_pkg::*;
#(
  parameter int WORD_SIZE    = 8,
  parameter int ROW_SIZE     = 540,
  parameter int IMAGE_HEIGHT = 360,
  parameter int KERNEL_SIZE  = 3,
  parameter int CONV_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 conv_en,
  output logic [WORD_SIZE-1:0] conv_pixel,
  output logic                 conv_clear,
  input  logic [WORD_SIZE-1:0] conv_result,
  conv_frame_ctrl_if.slave     sif,
  output state_t               dbg_state
);

  localparam int ROW_W = cnt_w(IMAGE_HEIGHT);
  localparam int COL_W = cnt_w(ROW_SIZE);
  localparam int K1    = KERNEL_SIZE - 1;

  state_t           state_q, state_d;
  logic [COL_W-1:0] in_col_q, in_col_d;
  logic [ROW_W-1:0] in_row_q, in_row_d;

  logic accept;
  logic col_end;
  logic last_px;
  logic pipe_empty;
  tag_t tag_in;
  tag_t tag_out;

  logic             m_valid;
  logic [ROW_W-1:0] m_row;
  logic [COL_W-1:0] m_col;

  assign accept  = (state_q == STREAM) && sif.s_valid;
  assign col_end = (in_col_q == COL_W'(ROW_SIZE - 1));
  assign last_px = accept && col_end && (in_row_q == ROW_W'(IMAGE_HEIGHT - 1));

  always_comb begin
    state_d  = state_q;
    in_col_d = in_col_q;
    in_row_d = in_row_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        in_col_d = '0;
        in_row_d = '0;
        state_d  = STREAM;
      end
      STREAM: begin
        if (accept) begin
          if (col_end) begin
            in_col_d = '0;
            in_row_d = in_row_q + 1'b1;
          end else begin
            in_col_d = in_col_q + 1'b1;
          end
          if (last_px) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (pipe_empty) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      in_col_q <= '0;
      in_row_q <= '0;
    end else begin
      state_q  <= state_d;
      in_col_q <= in_col_d;
      in_row_q <= in_row_d;
    end
  end

  // A shift only yields a result once the KxK window behind it is fully populated.
  always_comb begin
    tag_in = '0;
    if (accept && (in_row_q >= ROW_W'(K1)) && (in_col_q >= COL_W'(K1))) begin
      tag_in.ok   = 1'b1;
      tag_in.orow = TAG_COORD_W'(in_row_q) - TAG_COORD_W'(K1);
      tag_in.ocol = TAG_COORD_W'(in_col_q) - TAG_COORD_W'(K1);
    end
  end

  conv_tag_pipe #(
    .DEPTH (CONV_LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out),
    .empty   (pipe_empty)
  );

  assign m_valid = tag_out.ok;
  assign m_row   = m_valid ? tag_out.orow[ROW_W-1:0] : '0;
  assign m_col   = m_valid ? tag_out.ocol[COL_W-1:0] : '0;

  assign sif.s_ready = (state_q == STREAM);
  assign sif.m_valid = m_valid;
  assign sif.m_pixel = m_valid ? conv_result : '0;
  assign sif.m_row   = m_row;
  assign sif.m_col   = m_col;
  assign sif.m_last  = m_valid
                    && (m_row == ROW_W'(IMAGE_HEIGHT - KERNEL_SIZE))
                    && (m_col == COL_W'(ROW_SIZE - KERNEL_SIZE));

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign conv_clear = (state_q == CLEAR);
  assign conv_en    = accept;
  assign conv_pixel = sif.s_pixel;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Bench for conv_frame_ctrl on a 5x4 frame with a 3x3 kernel and a two-cycle
// window-sum datapath model; expected outputs are queued as pixels are accepted.
module tb_conv_frame_ctrl;
  import conv_pkg::*;

  localparam int WS    = 8;
  localparam int W     = 5;
  localparam int H     = 4;
  localparam int K     = 3;
  localparam int LAT   = 2;
  localparam int ROW_W = 2;
  localparam int COL_W = 3;
  localparam int EXP_W = 32 + 1 + ROW_W + COL_W + WS;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          busy, done, conv_en, conv_clear;
  logic [WS-1:0] conv_pixel, conv_result;
  state_t        dbg_state;

  conv_frame_ctrl_if #(.WORD_SIZE(WS), .ROW_W(ROW_W), .COL_W(COL_W)) sif ();

  conv_frame_ctrl #(
    .WORD_SIZE    (WS),
    .ROW_SIZE     (W),
    .IMAGE_HEIGHT (H),
    .KERNEL_SIZE  (K),
    .CONV_LATENCY (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .conv_en     (conv_en),
    .conv_pixel  (conv_pixel),
    .conv_clear  (conv_clear),
    .conv_result (conv_result),
    .sif         (sif),
    .dbg_state   (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // stimulus and reference helpers
  function automatic logic [WS-1:0] pix(input int idx);
    return WS'(idx * 7 + 3);
  endfunction

  function automatic logic [WS-1:0] exp_sum(input int idx);
    int r = idx / W;
    int c = idx % W;
    int s = 0;
    for (int dr = 0; dr < K; dr++)
      for (int dc = 0; dc < K; dc++)
        s += int'(pix((r - dr) * W + (c - dc)));
    return WS'(s);
  endfunction

  // datapath model: window sum over the pixels it actually received, two cycles late
  logic [WS-1:0] hist [0:31];
  logic [WS-1:0] p0, p1;
  int            acc_n;

  function automatic logic [WS-1:0] model_sum(input int n);
    int r = n / W;
    int c = n % W;
    int s = 0;
    if (r < K - 1 || c < K - 1) return '0;
    for (int dr = 0; dr < K; dr++)
      for (int dc = 0; dc < K; dc++)
        s += int'(hist[(r - dr) * W + (c - dc)]);
    return WS'(s);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p0    <= '0;
      p1    <= '0;
      acc_n <= 0;
    end else begin
      if (conv_clear) begin
        acc_n <= 0;
      end else if (conv_en) begin
        hist[acc_n % 32] = conv_pixel;
        acc_n <= acc_n + 1;
      end
      p0 <= conv_en ? model_sum(acc_n) : '0;
      p1 <= p0;
    end
  end
  assign conv_result = p1;

  // scoreboard
  logic [EXP_W-1:0] exp_q[$];
  int out_cnt, last_cnt, done_cnt, clear_cnt, en_cnt;
  logic prev_clear = 1'b0;

  task automatic push_exp(input int idx);
    int r = idx / W;
    int c = idx % W;
    if (r >= K - 1 && c >= K - 1) begin
      exp_q.push_back({32'(cyc + LAT), (r == H - 1 && c == W - 1),
                       ROW_W'(r - (K - 1)), COL_W'(c - (K - 1)), exp_sum(idx)});
    end
  endtask

  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (conv_clear) clear_cnt++;
    if (prev_clear) check("clear_then_ready", sif.s_ready, 1);
    prev_clear = conv_clear;
    if (conv_en)     en_cnt++;
    if (done)        done_cnt++;
    if (sif.m_last)  last_cnt++;
    if (sif.m_valid) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out row=%0d col=%0d pix=%0h queue empty", sif.m_row, sif.m_col, sif.m_pixel);
      end else begin
        e = exp_q.pop_front();
        check("out_cyc_last_row_col_pix",
              {32'(cyc), sif.m_last, sif.m_row, sif.m_col, sif.m_pixel}, e);
      end
    end else begin
      check("idle_out_zero", {sif.m_row, sif.m_col, sif.m_last, sif.m_pixel}, 0);
    end
  end

  // driver tasks
  task automatic reset_counts();
    out_cnt = 0; last_cnt = 0; done_cnt = 0; clear_cnt = 0; en_cnt = 0;
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic drive_frame(input bit bubble, input int start_idx, input int n_px);
    int  idx    = 0;
    int  c      = 0;
    bit  pulsed = 0;
    while (idx < n_px && c < 100) begin
      @(negedge clk);
      start = 1'b0;
      if (!pulsed && idx == start_idx) begin
        start  = 1'b1;
        pulsed = 1;
      end
      if (bubble && (c % 3 == 2)) begin
        sif.s_valid = 1'b0;
        sif.s_pixel = '0;
      end else begin
        sif.s_valid = 1'b1;
        sif.s_pixel = pix(idx);
        if (sif.s_ready) begin
          push_exp(idx);
          idx++;
        end
      end
      c++;
    end
    @(negedge clk);
    sif.s_valid = 1'b0;
    sif.s_pixel = '0;
    start       = 1'b0;
    check("drive_accepted", idx, n_px);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
  endtask

  task automatic finish_frame(input int e_out, input int e_last, input int e_done,
                              input int e_clear, input int e_en);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("state_idle", 64'(dbg_state), 64'(IDLE));
    check("out_count", out_cnt, e_out);
    check("last_count", last_cnt, e_last);
    check("done_count", done_cnt, e_done);
    check("clear_count", clear_cnt, e_clear);
    check("conv_en_count", en_cnt, e_en);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    sif.s_valid = 1'b0;
    sif.s_pixel = '0;
    reset_counts();

    // reset state
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {busy, done, sif.s_ready, conv_en, conv_clear, sif.m_valid, sif.m_last,
           sif.m_pixel, sif.m_row, sif.m_col, conv_pixel}, 0);
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // continuous frame
    reset_counts();
    do_start();
    drive_frame(0, -1, W * H);
    wait_done();
    finish_frame(6, 1, 1, 1, W * H);

    // bubbles every third cycle
    reset_counts();
    do_start();
    drive_frame(1, -1, W * H);
    wait_done();
    finish_frame(6, 1, 1, 1, W * H);

    // start pulses in STREAM and FLUSH are ignored
    reset_counts();
    do_start();
    drive_frame(0, 7, W * H);
    check("in_flush", 64'(dbg_state), 64'(FLUSH));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    finish_frame(6, 1, 1, 1, W * H);
    repeat (3) @(negedge clk);
    check("no_restart", 64'(dbg_state), 64'(IDLE));

    // mid-frame asynchronous reset, then a clean frame
    reset_counts();
    do_start();
    drive_frame(0, -1, 10);
    check("busy_mid_frame", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outputs", {busy, sif.s_ready, sif.m_valid, done, conv_clear}, 0);
    check("async_rst_state", 64'(dbg_state), 64'(IDLE));
    check("no_pending_outputs", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("no_done_aborted", done_cnt, 0);
    reset_counts();
    do_start();
    drive_frame(0, -1, W * H);
    wait_done();
    finish_frame(6, 1, 1, 1, W * H);

    // back-to-back frames, second start right after done
    reset_counts();
    do_start();
    drive_frame(0, -1, W * H);
    wait_done();
    do_start();
    drive_frame(0, -1, W * H);
    wait_done();
    finish_frame(12, 2, 2, 2, 2 * W * H);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
